// File: rtl/bus_sync_scheduler.sv
// Round-robin scheduler that shares one DATA_SYNC crossing among several requesters,
// driving unsync_bus/bus_enable with a hold-then-gap envelope per transfer.
module bus_sync_scheduler #(
  parameter int D_WIDTH     = 8,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       sched_en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*D_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       done,
  output logic                       busy,
  output logic [D_WIDTH-1:0]         unsync_bus,
  output logic                       bus_enable
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(NUM_REQ);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [D_WIDTH-1:0]  bus_q, bus_d;
  logic                en_q, en_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                done_q, done_d;

  logic                found;
  logic [PW-1:0]       sel;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    return PW'((int'(base) + off) % NUM_REQ);
  endfunction

  // First asserted request at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[wrap_idx(ptr_q, i)]) begin
        found = 1'b1;
        sel   = wrap_idx(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    en_d    = en_q;
    gnt_d   = '0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sched_en && found) begin
          state_d = HOLD;
          ptr_d   = wrap_idx(sel, 1);
          cnt_d   = HOLD_LOAD;
          bus_d   = req_data[sel*D_WIDTH +: D_WIDTH];
          en_d    = 1'b1;
          gnt_d   = NUM_REQ'(1) << sel;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        // done lands in the first IDLE cycle, where a new grant may also be taken.
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      bus_q   <= '0;
      en_q    <= 1'b0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
  assign unsync_bus = bus_q;
  assign bus_enable = en_q;

endmodule
